// File: rtl/oflow_mem_buffer_arbiter_pkg.sv
// Shared types and widths for the history-frame MEM buffer arbiter.
package oflow_mem_arb_pkg;

   localparam int FRAME_W    = 8;
   localparam int OFFSET_W   = 6;
   localparam int DATA_WIDTH = 32;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WRITE = 2'd1,
      DONE  = 2'd2
   } arb_state_t;

   typedef struct packed {
      logic                  we;
      logic [FRAME_W-1:0]    frame;
      logic [OFFSET_W-1:0]   off0;
      logic [OFFSET_W-1:0]   off1;
      logic [DATA_WIDTH-1:0] d0;
      logic [DATA_WIDTH-1:0] d1;
   } mem_cmd_t;

endpackage

// File: rtl/oflow_mem_buffer_arbiter_if.sv
// Bundle of requester, read-side and MEM buffer signals around the arbiter.
interface oflow_mem_buffer_arbiter_if #(
   parameter int NUM_REQ = 4
);
   import oflow_mem_arb_pkg::*;

   logic                          frame_start;
   logic [FRAME_W-1:0]            frame_num;
   logic [OFFSET_W:0]             num_of_bbox_in_frame;
   logic [NUM_REQ-1:0]            wr_req;
   logic [NUM_REQ*DATA_WIDTH-1:0] wr_data_0;
   logic [NUM_REQ*DATA_WIDTH-1:0] wr_data_1;
   logic [NUM_REQ-1:0]            wr_gnt;
   logic                          rd_req;
   logic [FRAME_W-1:0]            rd_frame;
   logic [OFFSET_W-1:0]           rd_offset;
   logic                          rd_gnt;
   logic                          rd_valid;
   logic                          frame_done;
   logic                          err_overlap;
   logic                          mem_we;
   logic [FRAME_W-1:0]            mem_frame_num;
   logic [OFFSET_W-1:0]           mem_offset_0;
   logic [OFFSET_W-1:0]           mem_offset_1;
   logic [DATA_WIDTH-1:0]         mem_data_in_0;
   logic [DATA_WIDTH-1:0]         mem_data_in_1;

   modport slave (
      input  frame_start, frame_num, num_of_bbox_in_frame,
      input  wr_req, wr_data_0, wr_data_1,
      input  rd_req, rd_frame, rd_offset,
      output wr_gnt, rd_gnt, rd_valid, frame_done, err_overlap,
      output mem_we, mem_frame_num, mem_offset_0, mem_offset_1,
      output mem_data_in_0, mem_data_in_1
   );

   modport master (
      output frame_start, frame_num, num_of_bbox_in_frame,
      output wr_req, wr_data_0, wr_data_1,
      output rd_req, rd_frame, rd_offset,
      input  wr_gnt, rd_gnt, rd_valid, frame_done, err_overlap,
      input  mem_we, mem_frame_num, mem_offset_0, mem_offset_1,
      input  mem_data_in_0, mem_data_in_1
   );

endinterface

// File: rtl/oflow_mem_buffer_arbiter_rr.sv
// Combinational round-robin picker: first requester after 'last', wrapping.
module oflow_rr_arbiter #(
   parameter int NUM_REQ = 4
) (
   input  logic [NUM_REQ-1:0]                                req,
   input  logic [((NUM_REQ > 1) ? $clog2(NUM_REQ) : 1)-1:0] last,
   output logic [NUM_REQ-1:0]                                gnt,
   output logic [((NUM_REQ > 1) ? $clog2(NUM_REQ) : 1)-1:0] idx
);
   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   logic [IDX_W-1:0] cand;
   logic             found;

   // NUM_REQ is a power of two, so index wrap is plain truncation.
   always_comb begin
      gnt   = '0;
      idx   = '0;
      found = 1'b0;
      cand  = '0;
      for (int i = 1; i <= NUM_REQ; i++) begin
         cand = last + IDX_W'(i);
         if (!found && req[cand]) begin
            found     = 1'b1;
            gnt[cand] = 1'b1;
            idx       = cand;
         end
      end
   end

endmodule

// File: rtl/oflow_mem_buffer_arbiter.sv
// Single-port MEM buffer arbiter: PE writes inside a frame window, reads win.
// Optional starvation guard enabled by defining OFLOW_ARB_STARVE_GUARD_EN.
//
// state | meaning
// IDLE  | no write window; only reads are arbitrated
// WRITE | window open for wr_frame; reads and PE writes arbitrated
// DONE  | all bboxes written; frame_done issued next cycle, back to IDLE
module oflow_mem_buffer_arbiter
   import oflow_mem_arb_pkg::*;
#(
   parameter int NUM_REQ = 4
`ifdef OFLOW_ARB_STARVE_GUARD_EN
   ,parameter int STARVE_LIMIT = 4
`endif
) (
   input logic                       clk,
   input logic                       reset_N,
   oflow_mem_buffer_arbiter_if.slave bus
);
   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int PTR_W = OFFSET_W + 2;

   arb_state_t         state_q, state_d;
   logic [FRAME_W-1:0] wr_frame_q;
   logic [PTR_W-1:0]   wr_total_q;
   logic [PTR_W-1:0]   wr_ptr_q;
   logic [IDX_W-1:0]   rr_last_q;
   logic               err_q;

   mem_cmd_t           cmd_q, cmd_d;
   logic [NUM_REQ-1:0] wr_gnt_q, wr_gnt_d;
   logic               rd_gnt_q, rd_gnt_d;
   logic               rd_valid_q;
   logic               frame_done_q, frame_done_d;

   logic [NUM_REQ-1:0]    wr_req_eff;
   logic                  rd_req_eff;
   logic [NUM_REQ-1:0]    arb_gnt;
   logic [IDX_W-1:0]      arb_idx;
   logic                  wr_pending;
   logic                  force_wr;
   logic                  rd_win;
   logic                  wr_win;
   logic                  last_write;
   logic                  odd_tail;
   logic [DATA_WIDTH-1:0] win_d0;
   logic [DATA_WIDTH-1:0] win_d1;
   logic [OFFSET_W-1:0]   wr_off0;

   // A grant already on the output is masked so a held request is not granted twice.
   assign wr_req_eff = bus.wr_req & ~wr_gnt_q;
   assign rd_req_eff = bus.rd_req & ~rd_gnt_q;

   oflow_rr_arbiter #(
      .NUM_REQ (NUM_REQ)
   ) u_rr (
      .req  (wr_req_eff),
      .last (rr_last_q),
      .gnt  (arb_gnt),
      .idx  (arb_idx)
   );

   assign wr_pending = (state_q == WRITE) && (|wr_req_eff);

`ifdef OFLOW_ARB_STARVE_GUARD_EN
   localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
   logic [CNT_W-1:0] starve_q;

   assign force_wr = (starve_q >= CNT_W'(STARVE_LIMIT));

   always_ff @(posedge clk or negedge reset_N) begin
      if (!reset_N) begin
         starve_q <= '0;
      end else if (wr_win) begin
         starve_q <= '0;
      end else if (rd_win && wr_pending && !force_wr) begin
         starve_q <= starve_q + CNT_W'(1);
      end
   end
`else
   assign force_wr = 1'b0;
`endif

   assign rd_win     = rd_req_eff && !(force_wr && wr_pending);
   assign wr_win     = wr_pending && !rd_win;
   assign last_write = wr_win && ((wr_ptr_q + PTR_W'(2)) >= wr_total_q);
   assign odd_tail   = (wr_ptr_q + PTR_W'(1)) == wr_total_q;
   assign wr_off0    = wr_ptr_q[OFFSET_W-1:0];
   assign win_d0     = bus.wr_data_0[int'(arb_idx)*DATA_WIDTH +: DATA_WIDTH];
   assign win_d1     = bus.wr_data_1[int'(arb_idx)*DATA_WIDTH +: DATA_WIDTH];

   always_ff @(posedge clk or negedge reset_N) begin
      if (!reset_N) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (bus.frame_start) begin
               state_d = (bus.num_of_bbox_in_frame == '0) ? DONE : WRITE;
            end
         end
         WRITE: begin
            if (last_write) state_d = DONE;
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Decision for this cycle; registered so the MEM sees it next cycle.
   always_comb begin
      cmd_d        = cmd_q;
      cmd_d.we     = 1'b0;
      wr_gnt_d     = '0;
      rd_gnt_d     = 1'b0;
      frame_done_d = (state_q == DONE);
      if (rd_win) begin
         rd_gnt_d    = 1'b1;
         cmd_d.frame = bus.rd_frame;
         cmd_d.off0  = bus.rd_offset;
         cmd_d.off1  = bus.rd_offset + OFFSET_W'(1);
      end else if (wr_win) begin
         wr_gnt_d    = arb_gnt;
         cmd_d.we    = 1'b1;
         cmd_d.frame = wr_frame_q;
         cmd_d.off0  = wr_off0;
         cmd_d.off1  = odd_tail ? wr_off0 : wr_off0 + OFFSET_W'(1);
         cmd_d.d0    = win_d0;
         cmd_d.d1    = odd_tail ? win_d0 : win_d1;
      end
   end

   always_ff @(posedge clk or negedge reset_N) begin
      if (!reset_N) begin
         wr_frame_q <= '0;
         wr_total_q <= '0;
         wr_ptr_q   <= '0;
         rr_last_q  <= IDX_W'(NUM_REQ - 1);
         err_q      <= 1'b0;
      end else begin
         if (state_q == IDLE && bus.frame_start) begin
            wr_frame_q <= bus.frame_num;
            wr_total_q <= PTR_W'(bus.num_of_bbox_in_frame);
            wr_ptr_q   <= '0;
         end else if (wr_win) begin
            wr_ptr_q <= wr_ptr_q + PTR_W'(2);
         end
         if (wr_win) rr_last_q <= arb_idx;
         if (bus.frame_start && state_q != IDLE) err_q <= 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset_N) begin
      if (!reset_N) begin
         cmd_q        <= '0;
         wr_gnt_q     <= '0;
         rd_gnt_q     <= 1'b0;
         rd_valid_q   <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         cmd_q        <= cmd_d;
         wr_gnt_q     <= wr_gnt_d;
         rd_gnt_q     <= rd_gnt_d;
         rd_valid_q   <= rd_gnt_q;
         frame_done_q <= frame_done_d;
      end
   end

   assign bus.wr_gnt        = wr_gnt_q;
   assign bus.rd_gnt        = rd_gnt_q;
   assign bus.rd_valid      = rd_valid_q;
   assign bus.frame_done    = frame_done_q;
   assign bus.err_overlap   = err_q;
   assign bus.mem_we        = cmd_q.we;
   assign bus.mem_frame_num = cmd_q.frame;
   assign bus.mem_offset_0  = cmd_q.off0;
   assign bus.mem_offset_1  = cmd_q.off1;
   assign bus.mem_data_in_0 = cmd_q.d0;
   assign bus.mem_data_in_1 = cmd_q.d1;

endmodule

// File: tb/tb_oflow_mem_buffer_arbiter.sv
// Directed bench for the MEM buffer arbiter, default build (no starvation guard).
module tb_oflow_mem_buffer_arbiter;

   logic clk = 1'b0;
   logic reset_N = 1'b0;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   oflow_mem_buffer_arbiter_if #(.NUM_REQ(4)) bus ();

   oflow_mem_buffer_arbiter #(.NUM_REQ(4)) dut (
      .clk     (clk),
      .reset_N (reset_N),
      .bus     (bus)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_wr(input string tag, input logic [3:0] gnt, input logic [7:0] frm,
                         input logic [5:0] o0, input logic [5:0] o1,
                         input logic [31:0] d0, input logic [31:0] d1);
      chk({tag, "_gnt"}, 64'(bus.wr_gnt), 64'(gnt));
      chk({tag, "_we"}, 64'(bus.mem_we), 64'(1));
      chk({tag, "_frame"}, 64'(bus.mem_frame_num), 64'(frm));
      chk({tag, "_off0"}, 64'(bus.mem_offset_0), 64'(o0));
      chk({tag, "_off1"}, 64'(bus.mem_offset_1), 64'(o1));
      chk({tag, "_d0"}, 64'(bus.mem_data_in_0), 64'(d0));
      chk({tag, "_d1"}, 64'(bus.mem_data_in_1), 64'(d1));
   endtask

   initial begin
      bus.frame_start          = 1'b0;
      bus.frame_num            = '0;
      bus.num_of_bbox_in_frame = '0;
      bus.wr_req               = '0;
      bus.rd_req               = 1'b0;
      bus.rd_frame             = '0;
      bus.rd_offset            = '0;
      for (int i = 0; i < 4; i++) begin
         bus.wr_data_0[i*32 +: 32] = 32'hA000_0000 + 32'(i);
         bus.wr_data_1[i*32 +: 32] = 32'hB000_0000 + 32'(i);
      end

      #3;
      chk("rst_wr_gnt", 64'(bus.wr_gnt), 64'(0));
      chk("rst_mem_we", 64'(bus.mem_we), 64'(0));
      chk("rst_rd_gnt", 64'(bus.rd_gnt), 64'(0));
      chk("rst_rd_valid", 64'(bus.rd_valid), 64'(0));
      chk("rst_frame_done", 64'(bus.frame_done), 64'(0));
      chk("rst_err", 64'(bus.err_overlap), 64'(0));
      chk("rst_off0", 64'(bus.mem_offset_0), 64'(0));
      chk("rst_data0", 64'(bus.mem_data_in_0), 64'(0));
      tick();
      reset_N = 1'b1;
      tick();

      // Four PEs, 16 bboxes: rr starts at PE0 after reset.
      bus.frame_start = 1'b1; bus.frame_num = 8'd9; bus.num_of_bbox_in_frame = 7'd16;
      bus.wr_req = 4'b1111;
      tick();
      bus.frame_start = 1'b0;
      for (int k = 0; k < 8; k++) begin
         tick();
         chk_wr($sformatf("all4_w%0d", k), 4'(1 << (k % 4)), 8'd9, 6'(2*k), 6'(2*k+1),
                32'hA000_0000 + 32'(k % 4), 32'hB000_0000 + 32'(k % 4));
      end
      bus.wr_req = 4'b0000;
      tick();
      chk("all4_done", 64'(bus.frame_done), 64'(1));
      chk("all4_done_we", 64'(bus.mem_we), 64'(0));
      chk("all4_done_gnt", 64'(bus.wr_gnt), 64'(0));
      tick();

      // Frame 5, 4 bboxes, PE0 and PE1.
      bus.frame_start = 1'b1; bus.frame_num = 8'd5; bus.num_of_bbox_in_frame = 7'd4;
      bus.wr_req = 4'b0011;
      tick();
      bus.frame_start = 1'b0;
      tick();
      chk_wr("f5_w0", 4'b0001, 8'd5, 6'd0, 6'd1, 32'hA000_0000, 32'hB000_0000);
      bus.wr_req = 4'b0010;
      tick();
      chk_wr("f5_w1", 4'b0010, 8'd5, 6'd2, 6'd3, 32'hA000_0001, 32'hB000_0001);
      chk("f5_done_early", 64'(bus.frame_done), 64'(0));
      bus.wr_req = 4'b0000;
      tick();
      chk("f5_done", 64'(bus.frame_done), 64'(1));
      chk("f5_idle_we", 64'(bus.mem_we), 64'(0));
      chk("f5_idle_hold_off0", 64'(bus.mem_offset_0), 64'(2));
      tick();
      chk("f5_done_pulse", 64'(bus.frame_done), 64'(0));

      // Odd tail: 3 bboxes from PE2 held continuously.
      bus.frame_start = 1'b1; bus.frame_num = 8'd3; bus.num_of_bbox_in_frame = 7'd3;
      bus.wr_req = 4'b0100;
      tick();
      bus.frame_start = 1'b0;
      tick();
      chk_wr("odd_w0", 4'b0100, 8'd3, 6'd0, 6'd1, 32'hA000_0002, 32'hB000_0002);
      tick();
      chk("odd_mask_gnt", 64'(bus.wr_gnt), 64'(0));
      chk("odd_mask_we", 64'(bus.mem_we), 64'(0));
      tick();
      chk_wr("odd_w1", 4'b0100, 8'd3, 6'd2, 6'd2, 32'hA000_0002, 32'hA000_0002);
      bus.wr_req = 4'b0000;
      tick();
      chk("odd_done", 64'(bus.frame_done), 64'(1));

      // Read with frame_start in the same cycle, then read beating a pending write.
      bus.frame_start = 1'b1; bus.frame_num = 8'd11; bus.num_of_bbox_in_frame = 7'd4;
      bus.wr_req = 4'b0001;
      bus.rd_req = 1'b1; bus.rd_frame = 8'd7; bus.rd_offset = 6'd4;
      tick();
      bus.frame_start = 1'b0;
      chk("rd0_gnt", 64'(bus.rd_gnt), 64'(1));
      chk("rd0_we", 64'(bus.mem_we), 64'(0));
      chk("rd0_frame", 64'(bus.mem_frame_num), 64'(7));
      chk("rd0_off", 64'({bus.mem_offset_0, bus.mem_offset_1}), 64'({6'd4, 6'd5}));
      chk("rd0_wgnt", 64'(bus.wr_gnt), 64'(0));
      bus.rd_req = 1'b0;
      tick();
      chk("rd0_valid", 64'(bus.rd_valid), 64'(1));
      chk_wr("rw_w0", 4'b0001, 8'd11, 6'd0, 6'd1, 32'hA000_0000, 32'hB000_0000);
      bus.rd_req = 1'b1;
      tick();
      chk("rd1_gnt", 64'(bus.rd_gnt), 64'(1));
      chk("rd1_we", 64'(bus.mem_we), 64'(0));
      chk("rd1_wgnt", 64'(bus.wr_gnt), 64'(0));
      tick();
      chk("rd1_valid", 64'(bus.rd_valid), 64'(1));
      chk("rd1_gnt_pulse", 64'(bus.rd_gnt), 64'(0));
      chk_wr("rw_w1", 4'b0001, 8'd11, 6'd2, 6'd3, 32'hA000_0000, 32'hB000_0000);
      bus.rd_req = 1'b0; bus.wr_req = 4'b0000;
      tick();
      chk("rw_done", 64'(bus.frame_done), 64'(1));
      tick();

      // Overlapping frame_start is flagged and does not disturb the window.
      bus.frame_start = 1'b1; bus.frame_num = 8'd2; bus.num_of_bbox_in_frame = 7'd8;
      tick();
      bus.frame_num = 8'd99; bus.num_of_bbox_in_frame = 7'd2;
      tick();
      bus.frame_start = 1'b0;
      chk("ovl_err", 64'(bus.err_overlap), 64'(1));
      bus.wr_req = 4'b0010;
      tick();
      chk_wr("ovl_w0", 4'b0010, 8'd2, 6'd0, 6'd1, 32'hA000_0001, 32'hB000_0001);
      bus.wr_req = 4'b0100;
      tick();
      chk_wr("ovl_w1", 4'b0100, 8'd2, 6'd2, 6'd3, 32'hA000_0002, 32'hB000_0002);
      chk("ovl_err_sticky", 64'(bus.err_overlap), 64'(1));

      // Asynchronous reset mid-frame.
      #3 reset_N = 1'b0;
      #1;
      chk("arst_gnt", 64'(bus.wr_gnt), 64'(0));
      chk("arst_we", 64'(bus.mem_we), 64'(0));
      chk("arst_err", 64'(bus.err_overlap), 64'(0));
      chk("arst_frame", 64'(bus.mem_frame_num), 64'(0));
      chk("arst_off0", 64'(bus.mem_offset_0), 64'(0));
      #2 reset_N = 1'b1;
      for (int k = 0; k < 3; k++) begin
         tick();
         chk($sformatf("post_rst_gnt%0d", k), 64'(bus.wr_gnt), 64'(0));
         chk($sformatf("post_rst_we%0d", k), 64'(bus.mem_we), 64'(0));
         chk($sformatf("post_rst_done%0d", k), 64'(bus.frame_done), 64'(0));
      end

      // Zero-bbox frame: straight to done, no writes even with a request held.
      bus.frame_start = 1'b1; bus.frame_num = 8'd4; bus.num_of_bbox_in_frame = 7'd0;
      tick();
      bus.frame_start = 1'b0;
      chk("zero_we0", 64'(bus.mem_we), 64'(0));
      chk("zero_gnt0", 64'(bus.wr_gnt), 64'(0));
      tick();
      chk("zero_done", 64'(bus.frame_done), 64'(1));
      chk("zero_we1", 64'(bus.mem_we), 64'(0));
      chk("zero_gnt1", 64'(bus.wr_gnt), 64'(0));
      tick();
      chk("zero_done_pulse", 64'(bus.frame_done), 64'(0));
      chk("zero_we2", 64'(bus.mem_we), 64'(0));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/oflow_mem_buffer_arbiter.md
Name: oflow_mem_buffer_arbiter

Overview:
Shares the single-port history-frame MEM buffer between NUM_REQ PE write requesters and one similarity-metric read requester. Writes are admitted only inside a frame-write window opened by frame_start. The block assigns bbox offsets in pairs (offset_0/offset_1) and reports frame completion. It sits between the PE array / similarity metric and the MEM buffer, replacing direct we/offset drive from the core FSM.

Parameters:
NUM_REQ, 4, number of PE write requesters (power of 2, 2..8)
DATA_WIDTH, 32, bbox data width per lane
FRAME_W, 8, frame-number width (frames 0-255)
OFFSET_W, 6, bbox offset width; max bboxes per frame = 2^OFFSET_W
STARVE_LIMIT, 4, consecutive read-won cycles before a pending write is forced (feature only)

Ports:
clk  in  1  clock
reset_N  in  1  asynchronous active-low reset
frame_start  in  1  pulse: opens write window for frame_num
frame_num  in  FRAME_W  frame being written
num_of_bbox_in_frame  in  OFFSET_W+1  bboxes expected this frame
wr_req  in  NUM_REQ  per-PE write request, held until granted
wr_data_0  in  NUM_REQ*DATA_WIDTH  flattened lane-0 data, slice i = PE i
wr_data_1  in  NUM_REQ*DATA_WIDTH  flattened lane-1 data
wr_gnt  out  NUM_REQ  one-hot grant pulse
rd_req  in  1  read request, held until rd_gnt
rd_frame  in  FRAME_W  history frame to read
rd_offset  in  OFFSET_W  even base offset; reads offset, offset+1
rd_gnt  out  1  read accepted pulse
rd_valid  out  1  MEM data_out valid (1 cycle after rd_gnt)
frame_done  out  1  pulse: all bboxes of frame written
err_overlap  out  1  sticky: frame_start received while writing
mem_we  out  1  MEM write enable
mem_frame_num  out  FRAME_W  MEM frame select
mem_offset_0  out  OFFSET_W  MEM lane-0 offset
mem_offset_1  out  OFFSET_W  MEM lane-1 offset
mem_data_in_0  out  DATA_WIDTH  MEM lane-0 write data
mem_data_in_1  out  DATA_WIDTH  MEM lane-1 write data

Behaviour:
- Reset: state IDLE; every output 0; wr_ptr=0; rr_last=NUM_REQ-1, so PE0 wins first; starve counter=0.
- States: IDLE (reads only); WRITE (reads and writes); DONE (one cycle, frame_done=1, then IDLE).
- IDLE->WRITE on frame_start: latch frame_num as wr_frame and num_of_bbox_in_frame as wr_total; wr_ptr=0. If wr_total==0, go straight to DONE with no writes.
- Arbitration is evaluated every cycle on current inputs. All grant/MEM outputs are registered: decision in cycle N, gnt and MEM command in cycle N+1. Exactly one MEM operation per cycle.
- A requester whose gnt is already in flight is masked in cycle N+1 so it is never double-granted.
- Priority: rd_req beats writes.
- Write grant: round-robin among wr_req, searching from rr_last+1 modulo NUM_REQ. rr_last updates to the winner.
- Write command: mem_we=1; mem_frame_num=wr_frame; mem_offset_0=wr_ptr; mem_offset_1=wr_ptr+1; data from the winner's slices.
- After each write grant, wr_ptr+=2.
- Odd tail: if wr_ptr+1==wr_total, then mem_offset_1=mem_offset_0 and mem_data_in_1=mem_data_in_0, so no stale cell is touched.
- When wr_ptr>=wr_total after an update: WRITE->DONE. Further wr_req get no grant.
- Read command: mem_we=0; mem_frame_num=rd_frame; offsets rd_offset, rd_offset+1. rd_valid=1 the following cycle.
- Idle cycle: mem_we=0, other MEM outputs hold their last value.
- frame_start in WRITE or DONE: ignored; err_overlap set until reset.
- rd_req and frame_start in the same cycle: both honoured (read granted, state enters WRITE).
- Reset mid-frame discards the write window; no frame_done is produced.

Optional Feature:
OFLOW_ARB_STARVE_GUARD_EN
- Defined: a counter increments each cycle rd_req wins while any wr_req is pending in WRITE. When it reaches STARVE_LIMIT, the next decision goes to a write. The counter clears on any write grant.
- Undefined: reads have strict priority; counter logic absent; STARVE_LIMIT unused.

Decomposition:
- Package oflow_mem_arb_pkg: state enum (IDLE, WRITE, DONE), FRAME_W/OFFSET_W constants, mem_cmd_t struct {we, frame, off0, off1, d0, d1}.
- Sub-module oflow_rr_arbiter (NUM_REQ): req vector plus last pointer in, one-hot grant plus index out; purely combinational.

Test Plan:
- Reset then frame_start, frame_num=5, num_of_bbox=4, wr_req=4'b0011 held -> gnt PE0 (offsets 0/1), then PE1 (offsets 2/3), both with frame 5; frame_done one cycle after the last write.
- All four PEs requesting, num_of_bbox=16 -> grant order 0,1,2,3,0,1,2,3; mem_we=1 on 8 consecutive cycles.
- num_of_bbox=3, one PE -> second write has offset_0=offset_1=2 and mem_data_in_1=mem_data_in_0; frame_done follows.
- rd_req held with wr_req pending, rd_frame=7, rd_offset=4 -> read granted (mem_we=0, offsets 4/5, rd_valid next cycle). With the guard enabled and STARVE_LIMIT=4, a write is granted on the 5th decision.
- frame_start mid-WRITE -> err_overlap=1, wr_ptr unaffected. num_of_bbox=0 -> frame_done with no mem_we.
- Assert reset_N low during WRITE -> all outputs 0 asynchronously; after release, wr_req gets no grant until a new frame_start.
